// File: rtl/mem_ctrl_pipe_reg_if.sv
`default_nettype none
//==============================================================================
// Module      : mem_ctrl_pipe_reg_if
// Description : Control/handshake bundle between ID/EXE, the MEM-stage control
//               pipeline register and the data memory.
// Revision    : 1.0 - initial release
//==============================================================================
interface mem_ctrl_pipe_reg_if #(
    parameter int CTRL_W = 3
);
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic              mem_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_valid;
    logic              stall_req;

    modport master (
        output in_ctrl, in_valid, stall, flush, mem_ready,
        input  out_ctrl, out_valid, stall_req
    );

    modport slave (
        input  in_ctrl, in_valid, stall, flush, mem_ready,
        output out_ctrl, out_valid, stall_req
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl_pipe_reg.sv
`default_nettype none
//==============================================================================
// Module      : mem_ctrl_pipe_reg
// Description : DEPTH-stage ID/EXE-to-MEM control pipeline with stall, flush
//               and memory-ready backpressure. Optional hold-cycle counter
//               enabled by defining MEM_CTRL_HOLD_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module mem_ctrl_pipe_reg #(
    parameter int                CTRL_W   = 3,
    parameter int                DEPTH    = 1,
    parameter logic [CTRL_W-1:0] MEM_MASK = 3'b111
) (
    input  logic               clk,
    input  logic               reset,
    mem_ctrl_pipe_reg_if.slave bus
`ifdef MEM_CTRL_HOLD_STATS_EN
    ,
    output logic [15:0]        hold_cycles
`endif
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("mem_ctrl_pipe_reg: DEPTH must be in 1..4");
    end

    logic              w_mem_pending;
    logic              w_hold;
    logic              w_advance;
    logic              w_out_valid;
    logic [CTRL_W-1:0] w_out_ctrl;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        localparam bit c_is_last = (i == DEPTH - 1);

        logic              r_valid;
        logic [CTRL_W-1:0] r_ctrl;
        logic              w_d_valid;
        logic [CTRL_W-1:0] w_d_ctrl;
        logic              w_keep;

        if (i == 0) begin : g_head
            // Bubbles always carry an all-zero bundle so MEM never sees stray enables.
            assign w_d_valid = bus.in_valid;
            assign w_d_ctrl  = bus.in_valid ? bus.in_ctrl : '0;
        end else begin : g_body
            assign w_d_valid = g_stage[i-1].r_valid;
            assign w_d_ctrl  = g_stage[i-1].r_ctrl;
        end

        // A memory op already waiting on mem_ready survives a flush.
        assign w_keep = c_is_last && w_hold;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else if (bus.flush) begin
                if (!w_keep) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end
            end else if (w_advance) begin
                r_valid <= w_d_valid;
                r_ctrl  <= w_d_ctrl;
            end
        end
    end

    assign w_out_valid   = g_stage[DEPTH-1].r_valid;
    assign w_out_ctrl    = g_stage[DEPTH-1].r_ctrl;
    assign w_mem_pending = w_out_valid & (|(w_out_ctrl & MEM_MASK));
    assign w_hold        = w_mem_pending & ~bus.mem_ready;
    assign w_advance     = ~bus.stall & ~w_hold;

    assign bus.out_valid = w_out_valid;
    assign bus.out_ctrl  = w_out_ctrl;
    assign bus.stall_req = w_hold;

`ifdef MEM_CTRL_HOLD_STATS_EN
    logic [15:0] r_hold_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cycles <= 16'd0;
        end else if (w_hold && (r_hold_cycles != 16'hFFFF)) begin
            r_hold_cycles <= r_hold_cycles + 16'd1;
        end
    end

    assign hold_cycles = r_hold_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_pipe_reg.sv
`default_nettype none
//==============================================================================
// Module      : tb_mem_ctrl_pipe_reg
// Description : Randomised scoreboard bench for mem_ctrl_pipe_reg (DEPTH=3).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mem_ctrl_pipe_reg;

    localparam int         CTRL_W   = 3;
    localparam int         DEPTH    = 3;
    localparam logic [2:0] MEM_MASK = 3'b111;
    localparam int         N_CYCLES = 4000;

    typedef struct {
        bit       valid;
        bit [2:0] ctrl;
    } slot_t;

    typedef struct {
        bit [2:0]  ctrl;
        bit        valid;
        bit        stall_req;
        bit [15:0] hold_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_ctrl_pipe_reg_if #(.CTRL_W(CTRL_W)) bus ();

`ifdef MEM_CTRL_HOLD_STATS_EN
    logic [15:0] hold_cycles;
`endif

    mem_ctrl_pipe_reg #(
        .CTRL_W   (CTRL_W),
        .DEPTH    (DEPTH),
        .MEM_MASK (MEM_MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_CTRL_HOLD_STATS_EN
        ,
        .hold_cycles (hold_cycles)
`endif
    );

    // Reference model: pipe[0] is the youngest entry, pipe[DEPTH-1] feeds MEM.
    slot_t     pipe[$];
    exp_t      exp_q[$];
    bit [15:0] m_hold_cnt;
    int        checks = 0;
    int        errors = 0;

    task automatic model_reset();
        pipe.delete();
        for (int k = 0; k < DEPTH; k++) pipe.push_back('{valid: 1'b0, ctrl: 3'b000});
        m_hold_cnt = 16'd0;
    endtask

    // Driver and model update
    initial begin
        slot_t o;
        bit    r_rst;
        bit    pending;
        bit    hold;
        bit    v_valid;
        bit [2:0] v_ctrl;
        bit    v_stall;
        bit    v_flush;
        bit    v_ready;

        reset         = 1'b1;
        bus.in_ctrl   = '0;
        bus.in_valid  = 1'b0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            r_rst   = (cyc < 3) || ($urandom_range(0, 249) == 0);
            v_valid = ($urandom_range(0, 9) < 7);
            v_ctrl  = 3'($urandom_range(0, 7));
            v_stall = ($urandom_range(0, 9) < 2);
            v_flush = ($urandom_range(0, 19) == 0);
            v_ready = ($urandom_range(0, 9) < 5);

            reset         = r_rst;
            bus.in_valid  = v_valid;
            bus.in_ctrl   = v_ctrl;
            bus.stall     = v_stall;
            bus.flush     = v_flush;
            bus.mem_ready = v_ready;
            if (r_rst) model_reset();

            o       = pipe[DEPTH-1];
            pending = o.valid && ((o.ctrl & MEM_MASK) != 3'b000);
            hold    = pending && !v_ready;
            exp_q.push_back('{ctrl: o.ctrl, valid: o.valid, stall_req: hold, hold_cnt: m_hold_cnt});

            if (!r_rst) begin
                if (hold && m_hold_cnt != 16'hFFFF) m_hold_cnt = m_hold_cnt + 16'd1;
                if (v_flush) begin
                    for (int k = 0; k < DEPTH; k++)
                        if (!(k == DEPTH - 1 && hold)) pipe[k] = '{valid: 1'b0, ctrl: 3'b000};
                end else if (!v_stall && !hold) begin
                    void'(pipe.pop_back());
                    pipe.push_front('{valid: v_valid, ctrl: (v_valid ? v_ctrl : 3'b000)});
                end
            end
        end

        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.out_ctrl !== e.ctrl || bus.out_valid !== e.valid ||
                    bus.stall_req !== e.stall_req) begin
                    errors++;
                    $display("FAIL outputs @%0t: ctrl=%b valid=%b stall_req=%b, expected ctrl=%b valid=%b stall_req=%b",
                             $time, bus.out_ctrl, bus.out_valid, bus.stall_req,
                             e.ctrl, e.valid, e.stall_req);
                end
`ifdef MEM_CTRL_HOLD_STATS_EN
                checks++;
                if (hold_cycles !== e.hold_cnt) begin
                    errors++;
                    $display("FAIL hold_cycles @%0t: got %0d, expected %0d",
                             $time, hold_cycles, e.hold_cnt);
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl_pipe_reg.md
Name: mem_ctrl_pipe_reg

Overview:
- Parametrised, clocked successor to the MEM-stage control-signal holder.
- Carries a CTRL_W-bit control bundle (default bits: Store_Byte, Mem_Write, Mem_Read) plus a valid bit from ID/EXE to MEM through DEPTH register stages.
- Adds stall, flush (bubble insertion) and memory-ready backpressure, none of which a pure pass-through provides.
- Sits between the ID/EXE register outputs and the data-memory control inputs.

Parameters:
- CTRL_W, 3, width of control bundle; bit0 = Mem_Read, bit1 = Mem_Write, bit2 = Store_Byte.
- DEPTH, 1, number of register stages, legal 1..4; any other value is a elaboration error.
- MEM_MASK, 3'b111, CTRL_W-bit mask of bundle bits that start a memory transaction.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_ctrl  input  CTRL_W  control bundle from ID/EXE.
- in_valid  input  1  in_ctrl carries a real instruction.
- stall  input  1  hazard-unit stall; freezes all stages.
- flush  input  1  kill all in-flight entries (insert bubbles).
- mem_ready  input  1  data memory accepts the operation presented this cycle.
- out_ctrl  output  CTRL_W  control bundle to MEM stage.
- out_valid  output  1  out_ctrl is a real instruction.
- stall_req  output  1  backpressure to hazard unit; memory not ready.

Behaviour:
- Storage: DEPTH entries {valid, ctrl}; entry 0 is loaded from inputs; entry DEPTH-1 drives out_ctrl/out_valid directly, with no combinational path from in_* to out_*.
- Reset (asynchronous, active-high): every entry valid=0, ctrl=0; hence out_ctrl=0, out_valid=0, stall_req=0 while reset is high and after release.
- mem_pending = out_valid & |(out_ctrl & MEM_MASK).
- hold = mem_pending & ~mem_ready.
- stall_req = hold; it is combinational from state and mem_ready.
- advance = ~stall & ~hold.
- On a rising edge with advance=1:
  - entry0 <= {in_valid, in_valid ? in_ctrl : 0}; an invalid input always loads an all-zero bundle.
  - entry[i] <= entry[i-1] for i = 1..DEPTH-1.
- On a rising edge with advance=0, all entries hold.
- Latency: DEPTH cycles from accepted input to out_*, with no stalls.
- Flush (highest priority over stall/advance):
  - All entries are cleared to {0,0}, except entry DEPTH-1 when hold=1.
  - A memory op already waiting on mem_ready is never aborted; it stays until mem_ready.
  - The input is not captured in a flush cycle.
- Simultaneous stall + hold: freeze; stall_req still reflects hold only.
- mem_ready is ignored when mem_pending=0, i.e. for a bubble or a non-memory op.
- A reset asserted mid-hold clears the pending op immediately; the memory side must tolerate the abort.
- DEPTH=1 behaves as a single ID/EXE-to-MEM register.

Optional Feature:
- Macro: MEM_CTRL_HOLD_STATS_EN.
- Defined:
  - Adds output port hold_cycles [15:0].
  - Increments on every rising edge where hold=1 and saturates at 16'hFFFF.
  - Reset clears it to 0; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- DEPTH=1, reset high then low; in_ctrl=3'b001, in_valid=1, mem_ready=1 -> cycle after edge: out_ctrl=3'b001, out_valid=1, stall_req=0.
- DEPTH=3; push 3'b001, 3'b010, 3'b100 on consecutive cycles -> each appears at out_ctrl exactly 3 cycles after its input edge, in order.
- DEPTH=2; out holds 3'b010 valid with mem_ready=0 for 4 cycles -> stall_req=1 for those 4 cycles, out_ctrl constant; with MEM_CTRL_HOLD_STATS_EN, hold_cycles=4; releases the cycle after mem_ready=1.
- DEPTH=2; both entries valid, no hold; assert flush one cycle -> next edge both entries valid=0, out_ctrl=0; in_ctrl during flush cycle discarded.
- Flush during hold (out=3'b001 pending, mem_ready=0) -> out_ctrl stays 3'b001 valid, entry 0 cleared; after mem_ready=1, the next out_valid=0.
- stall=1 for 2 cycles with in_valid=1, in_ctrl=3'b100 -> outputs frozen; in_valid=0 then loads ctrl 0; assert reset mid-stall -> all outputs 0 asynchronously.
